// File: rtl/axi4_resp_pkg.sv
// rtl/axi4_resp_pkg.sv - AXI4 response/burst encodings and responder FSM state types
package axi4_resp_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Only full-width 32-bit beats are served
    localparam logic [2:0] SIZE_4B = 3'b010;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

endpackage

// File: rtl/axi4_mem_dp_bram.sv
// rtl/axi4_mem_dp_bram.sv - simple dual-port RAM, byte-enable write port, registered read-first read port
module axi4_mem_dp_bram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // Byte-lane write; contents survive reset on purpose
    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_W/8; b++) begin
            if (wr_en && wr_be[b]) begin
                mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Registered read; sees the pre-write word on a same-cycle collision
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/axi4_burst_mem_responder.sv
// rtl/axi4_burst_mem_responder.sv - AXI4 burst slave memory with independent read and write FSMs
module axi4_burst_mem_responder
    import axi4_resp_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_MEM_ADDR_WIDTH   = 10,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int IW = C_S_AXI_ID_WIDTH;
    localparam int MW = C_MEM_ADDR_WIDTH;
    localparam logic [AW-1:0] WIN_BYTES = AW'(4 << MW);

    // True when the byte address lies inside the memory window (borrow bit catches addr < base)
    function automatic logic in_window(input logic [AW-1:0] a);
        logic [AW:0] off;
        off = {1'b0, a} - {1'b0, C_BASE_ADDR};
        return !off[AW] && (off[AW-1:0] < WIN_BYTES);
    endfunction

    function automatic logic [MW-1:0] word_index(input logic [AW-1:0] a);
        return MW'((a - C_BASE_ADDR) >> 2);
    endfunction

    // ---------------- write channel state ----------------
    wr_state_e       w_state_q, w_state_d;
    logic            awready_q, awready_d;
    logic            wready_q, wready_d;
    logic            bvalid_q, bvalid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic [IW-1:0]   bid_q, bid_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [7:0]      wlen_q, wlen_d;
    logic [7:0]      wcnt_q, wcnt_d;
    logic            winc_q, winc_d;
    logic            wbad_q, wbad_d;
    logic            wdec_q, wdec_d;
    logic            mem_we, w_in, w_final;

    // ---------------- read channel state ----------------
    rd_state_e       r_state_q, r_state_d;
    logic            arready_q, arready_d;
    logic [IW-1:0]   rid_q, rid_d;
    logic [AW-1:0]   raddr_q, raddr_d;
    logic [7:0]      rlen_q, rlen_d;
    logic [7:0]      rcnt_q, rcnt_d;
    logic            rinc_q, rinc_d;
    logic            rbad_q, rbad_d;
    logic            rdone_q, rdone_d;
    logic            p1_valid_q, p1_valid_d;
    logic [1:0]      p1_resp_q, p1_resp_d;
    logic            p1_last_q, p1_last_d;
    logic            p1_zero_q, p1_zero_d;
    logic            rvalid_q, rvalid_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      rresp_q, rresp_d;
    logic            rlast_q, rlast_d;
    logic            sk_valid_q, sk_valid_d;
    logic [DW-1:0]   sk_data_q, sk_data_d;
    logic [1:0]      sk_resp_q, sk_resp_d;
    logic            sk_last_q, sk_last_d;
    logic            pop, issue, r_in;
    logic [1:0]      fill;
    logic [DW-1:0]   ram_rd_data, in_data;

    axi4_mem_dp_bram #(
        .ADDR_W (MW),
        .DATA_W (DW)
    ) u_mem (
        .clk     (ACLK),
        .wr_en   (mem_we),
        .wr_addr (word_index(waddr_q)),
        .wr_data (S_AXI_WDATA),
        .wr_be   (S_AXI_WSTRB),
        .rd_en   (issue),
        .rd_addr (word_index(raddr_q)),
        .rd_data (ram_rd_data)
    );

    // Write FSM next state: latch AW, store beats, then hold the B response
    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        bid_d     = bid_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wcnt_d    = wcnt_q;
        winc_d    = winc_q;
        wbad_d    = wbad_q;
        wdec_d    = wdec_q;
        mem_we    = 1'b0;
        w_in      = in_window(waddr_q);
        w_final   = (wcnt_q == wlen_q) || S_AXI_WLAST;
        case (w_state_q)
            W_IDLE: begin
                if (S_AXI_AWVALID) begin
                    bid_d     = S_AXI_AWID;
                    waddr_d   = S_AXI_AWADDR;
                    wlen_d    = S_AXI_AWLEN;
                    winc_d    = (S_AXI_AWBURST == BURST_INCR);
                    // WRAP and the reserved encoding are both refused
                    wbad_d    = S_AXI_AWBURST[1] || (S_AXI_AWSIZE != SIZE_4B);
                    wdec_d    = 1'b0;
                    wcnt_d    = '0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (S_AXI_WVALID) begin
                    mem_we = !wbad_q && w_in;
                    if (!w_in) begin
                        wdec_d = 1'b1;
                    end
                    if (w_final) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        w_state_d = W_RESP;
                        if (wbad_q) begin
                            bresp_d = RESP_SLVERR;
                        end else if (wdec_q || !w_in) begin
                            bresp_d = RESP_DECERR;
                        end else if (S_AXI_WLAST != (wcnt_q == wlen_q)) begin
                            bresp_d = RESP_SLVERR;
                        end else begin
                            bresp_d = RESP_OKAY;
                        end
                    end else begin
                        wcnt_d = wcnt_q + 8'd1;
                        if (winc_q) begin
                            waddr_d = waddr_q + AW'(4);
                        end
                    end
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write channel registers
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            winc_q    <= 1'b0;
            wbad_q    <= 1'b0;
            wdec_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            winc_q    <= winc_d;
            wbad_q    <= wbad_d;
            wdec_q    <= wdec_d;
        end
    end

    // Read FSM next state: issue RAM reads only when the output pair has room, then drain through out/skid
    always_comb begin
        r_state_d  = r_state_q;
        arready_d  = arready_q;
        rid_d      = rid_q;
        raddr_d    = raddr_q;
        rlen_d     = rlen_q;
        rcnt_d     = rcnt_q;
        rinc_d     = rinc_q;
        rbad_d     = rbad_q;
        rdone_d    = rdone_q;
        p1_resp_d  = p1_resp_q;
        p1_last_d  = p1_last_q;
        p1_zero_d  = p1_zero_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        sk_valid_d = sk_valid_q;
        sk_data_d  = sk_data_q;
        sk_resp_d  = sk_resp_q;
        sk_last_d  = sk_last_q;
        r_in       = in_window(raddr_q);
        pop        = rvalid_q && S_AXI_RREADY;
        in_data    = p1_zero_q ? '0 : ram_rd_data;
        // Beats that will sit in out/skid after this edge; a new read needs one free slot
        fill       = {1'b0, rvalid_q} + {1'b0, sk_valid_q} + {1'b0, p1_valid_q} - {1'b0, pop};
        issue      = (r_state_q == R_DATA) && !rdone_q && (fill <= 2'd1);
        p1_valid_d = issue;

        if (issue) begin
            p1_zero_d = rbad_q || !r_in;
            p1_resp_d = rbad_q ? RESP_SLVERR : (r_in ? RESP_OKAY : RESP_DECERR);
            p1_last_d = (rcnt_q == rlen_q);
            if (rcnt_q == rlen_q) begin
                rdone_d = 1'b1;
            end else begin
                rcnt_d = rcnt_q + 8'd1;
                if (rinc_q) begin
                    raddr_d = raddr_q + AW'(4);
                end
            end
        end

        if (pop && sk_valid_q) begin
            rvalid_d   = 1'b1;
            rdata_d    = sk_data_q;
            rresp_d    = sk_resp_q;
            rlast_d    = sk_last_q;
            sk_valid_d = p1_valid_q;
            if (p1_valid_q) begin
                sk_data_d = in_data;
                sk_resp_d = p1_resp_q;
                sk_last_d = p1_last_q;
            end
        end else if (pop || !rvalid_q) begin
            rvalid_d = p1_valid_q;
            rlast_d  = p1_valid_q && p1_last_q;
            if (p1_valid_q) begin
                rdata_d = in_data;
                rresp_d = p1_resp_q;
            end
        end else if (p1_valid_q) begin
            sk_valid_d = 1'b1;
            sk_data_d  = in_data;
            sk_resp_d  = p1_resp_q;
            sk_last_d  = p1_last_q;
        end

        case (r_state_q)
            R_IDLE: begin
                if (S_AXI_ARVALID) begin
                    rid_d     = S_AXI_ARID;
                    raddr_d   = S_AXI_ARADDR;
                    rlen_d    = S_AXI_ARLEN;
                    rinc_d    = (S_AXI_ARBURST == BURST_INCR);
                    rbad_d    = S_AXI_ARBURST[1] || (S_AXI_ARSIZE != SIZE_4B);
                    rcnt_d    = '0;
                    rdone_d   = 1'b0;
                    arready_d = 1'b0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (pop && rlast_q) begin
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read channel registers
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state_q  <= R_IDLE;
            arready_q  <= 1'b1;
            rid_q      <= '0;
            raddr_q    <= '0;
            rlen_q     <= '0;
            rcnt_q     <= '0;
            rinc_q     <= 1'b0;
            rbad_q     <= 1'b0;
            rdone_q    <= 1'b0;
            p1_valid_q <= 1'b0;
            p1_resp_q  <= RESP_OKAY;
            p1_last_q  <= 1'b0;
            p1_zero_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rlast_q    <= 1'b0;
            sk_valid_q <= 1'b0;
            sk_data_q  <= '0;
            sk_resp_q  <= RESP_OKAY;
            sk_last_q  <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            arready_q  <= arready_d;
            rid_q      <= rid_d;
            raddr_q    <= raddr_d;
            rlen_q     <= rlen_d;
            rcnt_q     <= rcnt_d;
            rinc_q     <= rinc_d;
            rbad_q     <= rbad_d;
            rdone_q    <= rdone_d;
            p1_valid_q <= p1_valid_d;
            p1_resp_q  <= p1_resp_d;
            p1_last_q  <= p1_last_d;
            p1_zero_q  <= p1_zero_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
            sk_valid_q <= sk_valid_d;
            sk_data_q  <= sk_data_d;
            sk_resp_q  <= sk_resp_d;
            sk_last_q  <= sk_last_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_BID     = bid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RID     = rid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RVALID  = rvalid_q;

endmodule

// File: tb/tb_axi4_burst_mem_responder.sv
// tb/tb_axi4_burst_mem_responder.sv - directed self-checking bench for the AXI4 burst memory responder
module tb_axi4_burst_mem_responder;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [0:0]  S_AXI_AWID;
    logic [31:0] S_AXI_AWADDR;
    logic [7:0]  S_AXI_AWLEN;
    logic [2:0]  S_AXI_AWSIZE;
    logic [1:0]  S_AXI_AWBURST;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WLAST;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [0:0]  S_AXI_BID;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [0:0]  S_AXI_ARID;
    logic [31:0] S_AXI_ARADDR;
    logic [7:0]  S_AXI_ARLEN;
    logic [2:0]  S_AXI_ARSIZE;
    logic [1:0]  S_AXI_ARBURST;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [0:0]  S_AXI_RID;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    axi4_burst_mem_responder dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWID    (S_AXI_AWID),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWLEN   (S_AXI_AWLEN),
        .S_AXI_AWSIZE  (S_AXI_AWSIZE),
        .S_AXI_AWBURST (S_AXI_AWBURST),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WLAST   (S_AXI_WLAST),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BID     (S_AXI_BID),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARID    (S_AXI_ARID),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARLEN   (S_AXI_ARLEN),
        .S_AXI_ARSIZE  (S_AXI_ARSIZE),
        .S_AXI_ARBURST (S_AXI_ARBURST),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RID     (S_AXI_RID),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RLAST   (S_AXI_RLAST),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rd_d [16];
    logic [1:0]  rd_r [16];
    logic        rd_l [16];
    int          rd_n;
    int          rd_first;
    logic [1:0]  got_bresp;
    logic [0:0]  got_bid;

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [0:0] id, input int nbeats, input int last_at,
                            output logic [1:0] bresp, output logic [0:0] bid);
        int  t;
        bit  to;
        to = 1'b0;
        S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len;
        S_AXI_AWSIZE = 3'b010; S_AXI_AWBURST = burst; S_AXI_AWVALID = 1'b1;
        t = 0;
        while (!S_AXI_AWREADY && t < 50) begin @(negedge ACLK); t++; end
        if (t >= 50) to = 1'b1;
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            S_AXI_WDATA = wd[i]; S_AXI_WSTRB = ws[i]; S_AXI_WLAST = (i == last_at); S_AXI_WVALID = 1'b1;
            t = 0;
            while (!S_AXI_WREADY && t < 50) begin @(negedge ACLK); t++; end
            if (t >= 50) to = 1'b1;
            @(negedge ACLK);
        end
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
        S_AXI_BREADY = 1'b1;
        t = 0;
        while (!S_AXI_BVALID && t < 50) begin @(negedge ACLK); t++; end
        if (t >= 50) to = 1'b1;
        bresp = S_AXI_BRESP;
        bid   = S_AXI_BID;
        n_checks++;
        if (to) begin $display("FAIL write_handshake_timeout addr=%h", addr); n_fail++; end
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
    endtask

    // mode 0: RREADY always high; mode 1: RREADY pattern 1,0,0 repeating
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [0:0] id, input int mode);
        int          t, cyc;
        bit          stalled;
        logic [31:0] hold_d;
        logic        hold_l;
        S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len;
        S_AXI_ARSIZE = 3'b010; S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1'b1;
        t = 0;
        while (!S_AXI_ARREADY && t < 50) begin @(negedge ACLK); t++; end
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        rd_n = 0; rd_first = -1; stalled = 1'b0; cyc = 0; hold_d = '0; hold_l = 1'b0;
        while (rd_n <= int'(len) && rd_n < 16 && cyc < 300) begin
            S_AXI_RREADY = (mode == 0) || (cyc % 3 == 0);
            if (S_AXI_RVALID) begin
                if (rd_first < 0) rd_first = cyc;
                if (stalled) begin
                    n_checks++;
                    if (S_AXI_RDATA !== hold_d || S_AXI_RLAST !== hold_l) begin
                        $display("FAIL stall_stable got=%h/%b want=%h/%b", S_AXI_RDATA, S_AXI_RLAST, hold_d, hold_l);
                        n_fail++;
                    end
                end
                if (S_AXI_RREADY) begin
                    rd_d[rd_n] = S_AXI_RDATA; rd_r[rd_n] = S_AXI_RRESP; rd_l[rd_n] = S_AXI_RLAST;
                    rd_n++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1; hold_d = S_AXI_RDATA; hold_l = S_AXI_RLAST;
                end
            end else if (stalled) begin
                n_checks++;
                $display("FAIL stall_rvalid_dropped got=0 want=1");
                n_fail++;
                stalled = 1'b0;
            end
            @(negedge ACLK);
            cyc++;
        end
        S_AXI_RREADY = 1'b0;
        n_checks++;
        if (rd_n !== int'(len) + 1) begin
            $display("FAIL read_beat_count got=%0d want=%0d", rd_n, int'(len) + 1); n_fail++;
        end
        n_checks++;
        if (rd_first !== 2) begin
            $display("FAIL read_first_latency got=%0d want=2", rd_first); n_fail++;
        end
        n_checks++;
        if (S_AXI_RVALID !== 1'b0 || S_AXI_ARREADY !== 1'b1) begin
            $display("FAIL read_end_state rvalid=%b arready=%b want 0/1", S_AXI_RVALID, S_AXI_ARREADY); n_fail++;
        end
        for (int i = 0; i < rd_n; i++) begin
            n_checks++;
            if (rd_l[i] !== (i == int'(len))) begin
                $display("FAIL rlast_beat%0d got=%b want=%b", i, rd_l[i], (i == int'(len))); n_fail++;
            end
        end
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        repeat (3) @(negedge ACLK);
        n_checks++;
        if (S_AXI_AWREADY !== 1'b1 || S_AXI_ARREADY !== 1'b1) begin
            $display("FAIL reset_ready aw=%b ar=%b want 1/1", S_AXI_AWREADY, S_AXI_ARREADY); n_fail++;
        end
        n_checks++;
        if ({S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID, S_AXI_RLAST} !== 4'b0000) begin
            $display("FAIL reset_valids got=%b want=0000", {S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID, S_AXI_RLAST}); n_fail++;
        end
        n_checks++;
        if (S_AXI_BRESP !== 2'b00 || S_AXI_RRESP !== 2'b00 || S_AXI_RDATA !== 32'h0 || S_AXI_BID !== 1'b0 || S_AXI_RID !== 1'b0) begin
            $display("FAIL reset_fields bresp=%b rresp=%b rdata=%h bid=%b rid=%b want zeros",
                     S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, S_AXI_BID, S_AXI_RID); n_fail++;
        end
        ARESET = 1'b0;
        @(negedge ACLK);
    endtask

    task automatic test_incr();
        logic [31:0] exp [4];
        exp[0] = 32'h0101FFFF; exp[1] = 32'hABCD0001; exp[2] = 32'hDEAD0011; exp[3] = 32'hBEEF0011;
        for (int i = 0; i < 4; i++) begin wd[i] = exp[i]; ws[i] = 4'hF; end
        do_write(32'h0, 8'd3, 2'b01, 1'b1, 4, 3, got_bresp, got_bid);
        n_checks++;
        if (got_bresp !== 2'b00 || got_bid !== 1'b1) begin
            $display("FAIL incr_bresp got=%b/%b want=00/1", got_bresp, got_bid); n_fail++;
        end
        do_read(32'h0, 8'd3, 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_d[i] !== exp[i] || rd_r[i] !== 2'b00) begin
                $display("FAIL incr_beat%0d got=%h/%b want=%h/00", i, rd_d[i], rd_r[i], exp[i]); n_fail++;
            end
        end
        n_checks++;
        if (S_AXI_RID !== 1'b1) begin $display("FAIL incr_rid got=%b want=1", S_AXI_RID); n_fail++; end
    endtask

    task automatic test_strobe();
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
        do_write(32'h10, 8'd0, 2'b01, 1'b0, 1, 0, got_bresp, got_bid);
        wd[0] = 32'h12345678; ws[0] = 4'b0101;
        do_write(32'h10, 8'd0, 2'b01, 1'b0, 1, 0, got_bresp, got_bid);
        do_read(32'h10, 8'd0, 1'b0, 0);
        n_checks++;
        if (rd_d[0] !== 32'hFF34FF78) begin $display("FAIL strobe_merge got=%h want=FF34FF78", rd_d[0]); n_fail++; end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 8; i++) begin wd[i] = 32'hC0DE0000 + 32'(i * 17); ws[i] = 4'hF; end
        do_write(32'h40, 8'd7, 2'b01, 1'b0, 8, 7, got_bresp, got_bid);
        do_read(32'h40, 8'd7, 1'b0, 1);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (rd_d[i] !== 32'hC0DE0000 + 32'(i * 17)) begin
                $display("FAIL stall_beat%0d got=%h want=%h", i, rd_d[i], 32'hC0DE0000 + 32'(i * 17)); n_fail++;
            end
        end
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hAAAA0000 + 32'(i); ws[i] = 4'hF; end
        do_write(32'hFF8, 8'd3, 2'b01, 1'b0, 4, 3, got_bresp, got_bid);
        n_checks++;
        if (got_bresp !== 2'b11) begin $display("FAIL oor_bresp got=%b want=11", got_bresp); n_fail++; end
        do_read(32'hFF8, 8'd3, 1'b0, 0);
        n_checks++;
        if (rd_d[0] !== 32'hAAAA0000 || rd_d[1] !== 32'hAAAA0001 || rd_r[0] !== 2'b00 || rd_r[1] !== 2'b00) begin
            $display("FAIL oor_inrange got=%h/%b %h/%b want=AAAA0000/00 AAAA0001/00", rd_d[0], rd_r[0], rd_d[1], rd_r[1]); n_fail++;
        end
        n_checks++;
        if (rd_d[2] !== 32'h0 || rd_d[3] !== 32'h0 || rd_r[2] !== 2'b11 || rd_r[3] !== 2'b11) begin
            $display("FAIL oor_outside got=%h/%b %h/%b want=0/11 0/11", rd_d[2], rd_r[2], rd_d[3], rd_r[3]); n_fail++;
        end
    endtask

    task automatic test_wrap_fixed();
        wd[0] = 32'h55555555; wd[1] = 32'h66666666; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(32'h0, 8'd1, 2'b10, 1'b0, 2, 1, got_bresp, got_bid);
        n_checks++;
        if (got_bresp !== 2'b10) begin $display("FAIL wrap_bresp got=%b want=10", got_bresp); n_fail++; end
        do_read(32'h0, 8'd1, 1'b0, 0);
        n_checks++;
        if (rd_d[0] !== 32'h0101FFFF || rd_d[1] !== 32'hABCD0001) begin
            $display("FAIL wrap_mem_unchanged got=%h %h want=0101FFFF ABCD0001", rd_d[0], rd_d[1]); n_fail++;
        end
        wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; ws[2] = 4'hF;
        do_write(32'h20, 8'd2, 2'b00, 1'b0, 3, 2, got_bresp, got_bid);
        n_checks++;
        if (got_bresp !== 2'b00) begin $display("FAIL fixed_bresp got=%b want=00", got_bresp); n_fail++; end
        do_read(32'h20, 8'd1, 1'b0, 0);
        n_checks++;
        if (rd_d[0] !== 32'h33333333) begin $display("FAIL fixed_last_wins got=%h want=33333333", rd_d[0]); n_fail++; end
    endtask

    task automatic test_len_mismatch();
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h77770000 + 32'(i); ws[i] = 4'hF; end
        do_write(32'h80, 8'd3, 2'b01, 1'b0, 2, 1, got_bresp, got_bid);
        n_checks++;
        if (got_bresp !== 2'b10) begin $display("FAIL early_wlast_bresp got=%b want=10", got_bresp); n_fail++; end
        do_write(32'h80, 8'd1, 2'b01, 1'b0, 2, -1, got_bresp, got_bid);
        n_checks++;
        if (got_bresp !== 2'b10) begin $display("FAIL missing_wlast_bresp got=%b want=10", got_bresp); n_fail++; end
        n_checks++;
        if (S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b0) begin
            $display("FAIL mismatch_idle aw=%b w=%b want 1/0", S_AXI_AWREADY, S_AXI_WREADY); n_fail++;
        end
    endtask

    task automatic test_reset_mid_read();
        int t, acc;
        S_AXI_ARID = 1'b0; S_AXI_ARADDR = 32'h40; S_AXI_ARLEN = 8'd7;
        S_AXI_ARSIZE = 3'b010; S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1'b1;
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b1;
        acc = 0; t = 0;
        while (acc < 2 && t < 50) begin
            if (S_AXI_RVALID) acc++;
            @(negedge ACLK);
            t++;
        end
        n_checks++;
        if (acc !== 2) begin $display("FAIL midreset_prefix got=%0d want=2", acc); n_fail++; end
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        S_AXI_RREADY = 1'b0;
        n_checks++;
        if (S_AXI_RVALID !== 1'b0 || S_AXI_ARREADY !== 1'b1) begin
            $display("FAIL midreset_abort rvalid=%b arready=%b want 0/1", S_AXI_RVALID, S_AXI_ARREADY); n_fail++;
        end
        @(negedge ACLK);
        do_read(32'h40, 8'd3, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_d[i] !== 32'hC0DE0000 + 32'(i * 17)) begin
                $display("FAIL midreset_reread%0d got=%h want=%h", i, rd_d[i], 32'hC0DE0000 + 32'(i * 17)); n_fail++;
            end
        end
    endtask

    initial begin
        ARESET = 1'b1;
        S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = 3'b010; S_AXI_AWBURST = 2'b01; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = 3'b010; S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        @(negedge ACLK);
        test_reset();
        test_incr();
        test_strobe();
        test_stall();
        test_out_of_range();
        test_wrap_fixed();
        test_len_mismatch();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
